// File: rtl/int_seq.sv
`default_nettype none
// ============================================================================
//  Module      : int_seq
//  Description : Interrupt sequencer for an 8-bit core. Synchronizes the NMI
//                and IRQ request lines, latches NMI edges, and steps the core
//                through the stack-push / vector-fetch sequence for reset,
//                NMI and IRQ, stalling on bus wait states.
//  Revision    : 1.0 - initial release
// ============================================================================
module int_seq #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       nmi_n,
    input  logic       irq_n,
    input  logic       i_flag,
    input  logic       inst_done,
    input  logic       mem_ready,
    output logic [1:0] vec_sel,
    output logic       vec_ld_lo,
    output logic       vec_ld_hi,
    output logic       push_en,
    output logic [1:0] push_sel,
    output logic       set_i,
    output logic       int_busy
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RST_W  = 3'd1;
    localparam logic [2:0] PUSH_H = 3'd2;
    localparam logic [2:0] PUSH_L = 3'd3;
    localparam logic [2:0] PUSH_P = 3'd4;
    localparam logic [2:0] VEC_L  = 3'd5;
    localparam logic [2:0] VEC_H  = 3'd6;

    localparam logic [1:0] KIND_NMI = 2'b01;
    localparam logic [1:0] KIND_RST = 2'b10;
    localparam logic [1:0] KIND_IRQ = 2'b11;

    localparam logic [1:0] SRC_PCH  = 2'b00;
    localparam logic [1:0] SRC_PCL  = 2'b01;
    localparam logic [1:0] SRC_STAT = 2'b10;

    logic [SYNC_STAGES-1:0] nmi_sync;
    logic [SYNC_STAGES-1:0] irq_sync;
    logic                   nmi_prev;
    logic                   nmi_s;
    logic                   irq_s;
    logic                   nmi_edge;
    logic                   nmi_pend;
    logic                   nmi_clr;
    logic [2:0]             state;
    logic [2:0]             state_nx;
    logic [1:0]             kind;
    logic [1:0]             kind_nx;

    assign nmi_s    = nmi_sync[SYNC_STAGES-1];
    assign irq_s    = irq_sync[SYNC_STAGES-1];
    assign nmi_edge = nmi_prev & ~nmi_s;

    // Synchronizer chains plus one extra flop holding the previous
    // synchronized NMI level for falling-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nmi_sync <= '1;
            irq_sync <= '1;
            nmi_prev <= 1'b1;
        end else begin
            nmi_sync <= {nmi_sync[SYNC_STAGES-2:0], nmi_n};
            irq_sync <= {irq_sync[SYNC_STAGES-2:0], irq_n};
            nmi_prev <= nmi_s;
        end
    end

    // The pending NMI is consumed when the sequence commits to the NMI
    // vector; a fresh edge in that same cycle wins and re-arms it.
    assign nmi_clr = (state == PUSH_P) && mem_ready && (kind_nx == KIND_NMI);

    // Pending-NMI latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nmi_pend <= 1'b0;
        end else begin
            nmi_pend <= nmi_edge | (nmi_pend & ~nmi_clr);
        end
    end

    // Next-state and interrupt-kind selection; every sequence step waits
    // for mem_ready, only the IDLE decision is paced by inst_done.
    always_comb begin
        state_nx = state;
        kind_nx  = kind;
        case (state)
            IDLE: begin
                if (inst_done) begin
                    if (nmi_pend) begin
                        state_nx = PUSH_H;
                        kind_nx  = KIND_NMI;
                    end else if (!irq_s && !i_flag) begin
                        state_nx = PUSH_H;
                        kind_nx  = KIND_IRQ;
                    end
                end
            end
            RST_W:  if (mem_ready) state_nx = VEC_L;
            PUSH_H: if (mem_ready) state_nx = PUSH_L;
            PUSH_L: if (mem_ready) state_nx = PUSH_P;
            PUSH_P: begin
                if (mem_ready) begin
                    state_nx = VEC_L;
                    // An NMI arriving during the pushes takes over the
                    // vector; the IRQ is dropped and re-sampled later.
                    if ((kind == KIND_IRQ) && nmi_pend) begin
                        kind_nx = KIND_NMI;
                    end
                end
            end
            VEC_L:  if (mem_ready) state_nx = VEC_H;
            VEC_H:  if (mem_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State and kind registers; reset parks in the reset-vector wait.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RST_W;
            kind  <= KIND_RST;
        end else begin
            state <= state_nx;
            kind  <= kind_nx;
        end
    end

    // Output decode from registered state/kind; set_i is additionally
    // qualified by mem_ready so it fires only on the VEC_H exit cycle.
    always_comb begin
        vec_sel   = 2'b00;
        vec_ld_lo = 1'b0;
        vec_ld_hi = 1'b0;
        push_en   = 1'b0;
        push_sel  = SRC_PCH;
        set_i     = 1'b0;
        int_busy  = (state != IDLE);
        case (state)
            RST_W:  vec_sel = kind;
            PUSH_H: begin
                push_en  = 1'b1;
                push_sel = SRC_PCH;
            end
            PUSH_L: begin
                push_en  = 1'b1;
                push_sel = SRC_PCL;
            end
            PUSH_P: begin
                push_en  = 1'b1;
                push_sel = SRC_STAT;
            end
            VEC_L: begin
                vec_sel   = kind;
                vec_ld_lo = 1'b1;
            end
            VEC_H: begin
                vec_sel   = kind;
                vec_ld_hi = 1'b1;
                set_i     = mem_ready;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_int_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_int_seq
//  Description : Directed self-checking bench for int_seq. Inputs change 1ns
//                after the rising edge, outputs are compared 2ns after it.
//                Output word: {int_busy, vec_sel, vec_ld_lo, vec_ld_hi,
//                push_en, push_sel, set_i}.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_int_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       nmi_n;
    logic       irq_n;
    logic       i_flag;
    logic       inst_done;
    logic       mem_ready;
    logic [1:0] vec_sel;
    logic       vec_ld_lo;
    logic       vec_ld_hi;
    logic       push_en;
    logic [1:0] push_sel;
    logic       set_i;
    logic       int_busy;
    logic [8:0] obs;

    int checks = 0;
    int errors = 0;

    localparam logic [8:0] O_IDLE = 9'b0_00_0_0_0_00_0;
    localparam logic [8:0] O_RSTW = 9'b1_10_0_0_0_00_0;
    localparam logic [8:0] O_PH   = 9'b1_00_0_0_1_00_0;
    localparam logic [8:0] O_PL   = 9'b1_00_0_0_1_01_0;
    localparam logic [8:0] O_PP   = 9'b1_00_0_0_1_10_0;
    localparam logic [8:0] O_VL_I = 9'b1_11_1_0_0_00_0;
    localparam logic [8:0] O_VH_I = 9'b1_11_0_1_0_00_1;
    localparam logic [8:0] O_VH_S = 9'b1_11_0_1_0_00_0;
    localparam logic [8:0] O_VL_N = 9'b1_01_1_0_0_00_0;
    localparam logic [8:0] O_VH_N = 9'b1_01_0_1_0_00_1;
    localparam logic [8:0] O_VL_R = 9'b1_10_1_0_0_00_0;
    localparam logic [8:0] O_VH_R = 9'b1_10_0_1_0_00_1;

    int_seq #(.SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .nmi_n     (nmi_n),
        .irq_n     (irq_n),
        .i_flag    (i_flag),
        .inst_done (inst_done),
        .mem_ready (mem_ready),
        .vec_sel   (vec_sel),
        .vec_ld_lo (vec_ld_lo),
        .vec_ld_hi (vec_ld_hi),
        .push_en   (push_en),
        .push_sel  (push_sel),
        .set_i     (set_i),
        .int_busy  (int_busy)
    );

    assign obs = {int_busy, vec_sel, vec_ld_lo, vec_ld_hi, push_en, push_sel, set_i};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset value, then the 3-cycle reset-vector sequence after release.
    task automatic test_reset();
        logic [8:0] e [4];
        e = '{O_RSTW, O_VL_R, O_VH_R, O_IDLE};
        tick();
        tick();
        #1;
        checks++;
        if (obs !== O_RSTW) begin
            errors++;
            $display("FAIL reset_hold got %b want %b", obs, O_RSTW);
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL reset_seq[%0d] got %b want %b", i, obs, e[i]);
            end
            tick();
        end
    endtask

    // IRQ level held low: no start without inst_done, then the 5-cycle
    // sequence; irq_n released mid-sequence must not abort it.
    task automatic test_irq();
        logic [8:0] e [7];
        e = '{O_IDLE, O_PH, O_PL, O_PP, O_VL_I, O_VH_I, O_IDLE};
        i_flag = 1'b0;
        irq_n  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (obs !== O_IDLE) begin
                errors++;
                $display("FAIL irq_no_inst_done[%0d] got %b want %b", i, obs, O_IDLE);
            end
            tick();
        end
        for (int i = 0; i < 7; i++) begin
            inst_done = (i == 0);
            if (i == 2) irq_n = 1'b1;
            #1;
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL irq_seq[%0d] got %b want %b", i, obs, e[i]);
            end
            tick();
        end
    endtask

    // A short IRQ glitch that is gone before inst_done is ignored.
    task automatic test_irq_drop();
        i_flag = 1'b0;
        irq_n  = 1'b0;
        tick();
        irq_n = 1'b1;
        tick();
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            inst_done = (i == 0);
            #1;
            checks++;
            if (obs !== O_IDLE) begin
                errors++;
                $display("FAIL irq_drop[%0d] got %b want %b", i, obs, O_IDLE);
            end
            tick();
        end
    endtask

    // Masked IRQ ignored; a 1-cycle NMI pulse is taken once, and only once.
    task automatic test_masked();
        logic [8:0] e [7];
        e = '{O_IDLE, O_PH, O_PL, O_PP, O_VL_N, O_VH_N, O_IDLE};
        i_flag = 1'b1;
        irq_n  = 1'b0;
        tick();
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            inst_done = (i == 0);
            #1;
            checks++;
            if (obs !== O_IDLE) begin
                errors++;
                $display("FAIL irq_masked[%0d] got %b want %b", i, obs, O_IDLE);
            end
            tick();
        end
        irq_n = 1'b1;
        nmi_n = 1'b0;
        tick();
        nmi_n = 1'b1;
        tick();
        tick();
        tick();
        for (int i = 0; i < 7; i++) begin
            inst_done = (i == 0);
            #1;
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL nmi_seq[%0d] got %b want %b", i, obs, e[i]);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            inst_done = (i == 0);
            #1;
            checks++;
            if (obs !== O_IDLE) begin
                errors++;
                $display("FAIL nmi_once[%0d] got %b want %b", i, obs, O_IDLE);
            end
            tick();
        end
    endtask

    // NMI whose synchronized fall lands in PUSH_L hijacks the IRQ vector;
    // the still-low IRQ is then taken afresh at the next inst_done.
    task automatic test_hijack();
        logic [8:0] e1 [7];
        logic [8:0] e2 [7];
        e1 = '{O_IDLE, O_PH, O_PL, O_PP, O_VL_N, O_VH_N, O_IDLE};
        e2 = '{O_IDLE, O_PH, O_PL, O_PP, O_VL_I, O_VH_I, O_IDLE};
        i_flag = 1'b0;
        irq_n  = 1'b0;
        tick();
        tick();
        tick();
        for (int i = 0; i < 7; i++) begin
            inst_done = (i == 0);
            nmi_n     = (i != 0);
            #1;
            checks++;
            if (obs !== e1[i]) begin
                errors++;
                $display("FAIL hijack_seq[%0d] got %b want %b", i, obs, e1[i]);
            end
            tick();
        end
        for (int i = 0; i < 7; i++) begin
            inst_done = (i == 0);
            if (i == 1) irq_n = 1'b1;
            #1;
            checks++;
            if (obs !== e2[i]) begin
                errors++;
                $display("FAIL hijack_irq_retake[%0d] got %b want %b", i, obs, e2[i]);
            end
            tick();
        end
    endtask

    // Three wait states in PUSH_P and in VEC_H: 11-cycle sequence, single set_i.
    task automatic test_stall();
        logic [8:0] e [13];
        logic       mr [13];
        e  = '{O_IDLE, O_PH, O_PL, O_PP, O_PP, O_PP, O_PP, O_VL_I,
               O_VH_S, O_VH_S, O_VH_S, O_VH_I, O_IDLE};
        mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
               1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        i_flag = 1'b0;
        irq_n  = 1'b0;
        tick();
        tick();
        tick();
        for (int i = 0; i < 13; i++) begin
            inst_done = (i == 0);
            mem_ready = mr[i];
            if (i == 1) irq_n = 1'b1;
            #1;
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL stall_seq[%0d] got %b want %b", i, obs, e[i]);
            end
            tick();
        end
        mem_ready = 1'b1;
    endtask

    // Reset in PUSH_L with an NMI pending: immediate reset outputs, reset
    // sequence, and the pending NMI is gone afterwards.
    task automatic test_reset_mid();
        logic [8:0] e [4];
        e = '{O_RSTW, O_VL_R, O_VH_R, O_IDLE};
        i_flag = 1'b0;
        irq_n  = 1'b0;
        tick();
        tick();
        tick();
        nmi_n = 1'b0;
        tick();
        nmi_n     = 1'b1;
        inst_done = 1'b1;
        tick();
        inst_done = 1'b0;
        irq_n     = 1'b1;
        #1;
        checks++;
        if (obs !== O_PH) begin
            errors++;
            $display("FAIL rmid_push_h got %b want %b", obs, O_PH);
        end
        tick();
        #1;
        checks++;
        if (obs !== O_PL) begin
            errors++;
            $display("FAIL rmid_push_l got %b want %b", obs, O_PL);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (obs !== O_RSTW) begin
            errors++;
            $display("FAIL rmid_async got %b want %b", obs, O_RSTW);
        end
        tick();
        #1;
        checks++;
        if (obs !== O_RSTW) begin
            errors++;
            $display("FAIL rmid_hold got %b want %b", obs, O_RSTW);
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL rmid_seq[%0d] got %b want %b", i, obs, e[i]);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            inst_done = (i == 0);
            #1;
            checks++;
            if (obs !== O_IDLE) begin
                errors++;
                $display("FAIL rmid_nmi_cleared[%0d] got %b want %b", i, obs, O_IDLE);
            end
            tick();
        end
    endtask

    initial begin
        reset     = 1'b1;
        nmi_n     = 1'b1;
        irq_n     = 1'b1;
        i_flag    = 1'b1;
        inst_done = 1'b0;
        mem_ready = 1'b1;
        test_reset();
        test_irq();
        test_irq_drop();
        test_masked();
        test_hijack();
        test_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/int_seq.md
INT_SEQ -- requirements
Module: int_seq

Interface
REQ-001 Parameter SYNC_STAGES, default 2, is the synchronizer depth for nmi_n and irq_n; legal values are 2 and 3.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 nmi_n  input  1  asynchronous NMI request, active low, edge-sensitive.
REQ-005 irq_n  input  1  asynchronous IRQ request, active low, level-sensitive.
REQ-006 i_flag  input  1  processor interrupt-disable flag; 1 masks IRQ.
REQ-007 inst_done  input  1  one-cycle pulse marking an instruction boundary.
REQ-008 mem_ready  input  1  bus ready; 0 stalls every sequence state.
REQ-009 vec_sel  output  2  vector select to the program counter: 00 none, 01 NMI, 10 reset, 11 IRQ.
REQ-010 vec_ld_lo  output  1  load the H register from datai (vector low byte).
REQ-011 vec_ld_hi  output  1  load the PC from datai/H (vector high byte).
REQ-012 push_en  output  1  stack write request.
REQ-013 push_sel  output  2  stack write source: 00 PCH, 01 PCL, 10 status with B=0.
REQ-014 set_i  output  1  one-cycle pulse that sets the I flag.
REQ-015 int_busy  output  1  sequence active; core holds instruction fetch.

Function
REQ-016 nmi_n and irq_n SHALL pass through SYNC_STAGES flip-flops before use; all behaviour below refers to the synchronized signals.
REQ-017 A synchronized 1->0 transition of nmi_n SHALL set nmi_pend; nmi_pend SHALL stay set until the sequence enters VEC_L with the NMI vector.
REQ-018 An NMI edge in the same cycle as the nmi_pend clear SHALL leave nmi_pend set.
REQ-019 The FSM states SHALL be IDLE, RST_W, PUSH_H, PUSH_L, PUSH_P, VEC_L and VEC_H.
REQ-020 Outputs SHALL be Moore outputs decoded from registered state and a registered 2-bit kind (01 NMI, 10 RST, 11 IRQ).
REQ-021 In IDLE, when inst_done=1: nmi_pend=1 SHALL go to PUSH_H with kind=NMI; otherwise irq_n=0 with i_flag=0 SHALL go to PUSH_H with kind=IRQ; otherwise the FSM SHALL stay in IDLE.
REQ-022 Outside inst_done, IDLE SHALL NOT start a sequence.
REQ-023 Each transition RST_W->VEC_L, PUSH_H->PUSH_L->PUSH_P->VEC_L, VEC_L->VEC_H and VEC_H->IDLE SHALL occur only on a cycle with mem_ready=1; otherwise the FSM SHALL hold state and all outputs.
REQ-024 PUSH_H, PUSH_L and PUSH_P SHALL assert push_en=1 with push_sel 00, 01 and 10 respectively.
REQ-025 NMI hijack: if nmi_pend=1 while kind=IRQ in PUSH_H, PUSH_L or PUSH_P, kind SHALL become NMI on leaving PUSH_P.
REQ-026 A hijacked IRQ SHALL be dropped and re-evaluated by level at a later inst_done.
REQ-027 vec_sel SHALL equal kind in RST_W, VEC_L and VEC_H, and SHALL be 00 in all other states.
REQ-028 VEC_L SHALL assert vec_ld_lo=1; VEC_H SHALL assert vec_ld_hi=1 and set_i=1.
REQ-029 set_i SHALL be high for exactly one cycle per sequence: the cycle VEC_H is exited with mem_ready=1.
REQ-030 While mem_ready=0, set_i SHALL be 0.
REQ-031 int_busy SHALL be 1 in every state except IDLE.
REQ-032 Latency from inst_done to VEC_H exit with mem_ready=1 throughout SHALL be 5 cycles for NMI/IRQ (PUSH_H, PUSH_L, PUSH_P, VEC_L, VEC_H).
REQ-033 An IRQ that deasserts before inst_done SHALL be ignored.
REQ-034 An IRQ that deasserts after sequence entry SHALL NOT abort the sequence.

Reset
REQ-035 Asserting reset SHALL immediately force state=RST_W, kind=RST, nmi_pend=0 and all synchronizer flops=1, regardless of state, including mid-sequence.
REQ-036 During reset the outputs SHALL be vec_sel=10, int_busy=1, vec_ld_lo=0, vec_ld_hi=0, push_en=0, push_sel=00 and set_i=0.
REQ-037 After reset release with mem_ready=1, the FSM SHALL pass RST_W->VEC_L->VEC_H->IDLE in 3 cycles, with no stack pushes.
REQ-038 The I flag SHALL be set by the set_i pulse in VEC_H.

Verification
REQ-039 Release reset with mem_ready=1 -> vec_sel=10 for 3 cycles; vec_ld_lo high in cycle 2; vec_ld_hi and set_i high in cycle 3; then int_busy=0 and push_en never 1.
REQ-040 With i_flag=0, hold irq_n=0 and pulse inst_done -> push_sel 00,01,10 on consecutive cycles, then vec_sel=11 with vec_ld_lo, then vec_ld_hi and set_i, for 5 cycles total.
REQ-041 With i_flag=1 and irq_n=0, pulse inst_done -> int_busy stays 0; then pulse nmi_n low for 1 cycle and pulse inst_done -> full sequence with vec_sel=01.
REQ-042 Start the IRQ sequence, then drop nmi_n during PUSH_L -> VEC_L/VEC_H show vec_sel=01, nmi_pend clears, and there is no second sequence for that edge.
REQ-043 Hold mem_ready=0 for 3 cycles in PUSH_P and in VEC_H -> state and outputs frozen, set_i pulses once, and total length is 5+6 cycles.
REQ-044 Assert reset during PUSH_L of an IRQ sequence -> outputs take reset values immediately, and after release the 3-cycle reset sequence runs with the pending NMI cleared.
